// File: rtl/ad1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ad1_pkg
//  Description : Shared constants and state encoding for the AD1 frame
//                sequencer (frame geometry, sample width, FSM codes).
//  Revision    : 1.0  initial release
// ============================================================================
package ad1_pkg;

    // Frame geometry: 16 SCLK bits per word, 4 leading zeros, 12-bit sample
    localparam int FRAME_BITS = 16;
    localparam int SAMPLE_W   = 12;
    localparam int LEAD_ZEROS = 4;

    // Sequencer state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LEAD    = 3'd1;
    localparam logic [2:0] ST_LOW     = 3'd2;
    localparam logic [2:0] ST_HIGH    = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_QUIET   = 3'd5;

    // True when the leading zero bits of a shifted word are all zero
    function automatic logic lead_ok(input logic [FRAME_BITS-1:0] word);
        return (word[FRAME_BITS-1 -: LEAD_ZEROS] == '0);
    endfunction

endpackage : ad1_pkg
`default_nettype wire

// File: rtl/ad1_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ad1_frame_sequencer_if
//  Description : Signal bundle between the frame sequencer (master) and the
//                shifter/ADC side (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface ad1_frame_sequencer_if;
    import ad1_pkg::*;

    logic                  EN;
    logic                  SCLK;
    logic                  CS;
    logic [FRAME_BITS-1:0] DATA1;
    logic [FRAME_BITS-1:0] DATA2;
    logic [SAMPLE_W-1:0]   SAMPLE1;
    logic [SAMPLE_W-1:0]   SAMPLE2;
    logic                  VALID;
    logic                  BUSY;
    logic                  ERR;

    modport master (
        input  EN, DATA1, DATA2,
        output SCLK, CS, SAMPLE1, SAMPLE2, VALID, BUSY, ERR
    );

    modport slave (
        output EN, DATA1, DATA2,
        input  SCLK, CS, SAMPLE1, SAMPLE2, VALID, BUSY, ERR
    );

endinterface : ad1_frame_sequencer_if
`default_nettype wire

// File: rtl/ad1_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ad1_tick_gen
//  Description : SCLK half-period timer. Counts CLK cycles while clear is low
//                and pulses tick on the last cycle of each CLK_DIV-long phase,
//                wrapping so back-to-back phases need no extra clear.
//  Revision    : 1.0  initial release
// ============================================================================
module ad1_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] c_last = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;

    assign tick = (r_cnt == c_last) && !clear;

    // Phase counter: restarts on clear or at the end of each phase
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= 8'd0;
        end else if (clear || tick) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule : ad1_tick_gen
`default_nettype wire

// File: rtl/ad1_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ad1_frame_sequencer
//  Description : Generates CS/SCLK framing for a dual-channel 16-bit shifter,
//                captures the 12-bit samples at frame end and strobes VALID.
//                Optional macro AD1_FRAME_CHECK_EN enables leading-zero
//                checking of each word with a sticky ERR flag.
//  Revision    : 1.0  initial release
// ============================================================================
module ad1_frame_sequencer
    import ad1_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int QUIET_CYCLES = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    ad1_frame_sequencer_if.master        bus
);

    localparam logic [7:0] c_quiet_last = 8'(QUIET_CYCLES - 1);

    logic [2:0]          r_state;
    logic [3:0]          r_bit_cnt;
    logic [7:0]          r_quiet_cnt;
    logic                r_cs;
    logic                r_sclk;
    logic                r_valid;
    logic [SAMPLE_W-1:0] r_sample1;
    logic [SAMPLE_W-1:0] r_sample2;
    logic                w_tick;
    logic                w_clear;
    logic                w_frame_ok;

    // The half-period timer only runs in the SCLK-timed states
    assign w_clear = !((r_state == ST_LEAD) || (r_state == ST_LOW) ||
                       (r_state == ST_HIGH));

    ad1_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .CLK   (CLK),
        .RST   (RST),
        .clear (w_clear),
        .tick  (w_tick)
    );

`ifdef AD1_FRAME_CHECK_EN
    logic r_err;

    assign w_frame_ok = lead_ok(bus.DATA1) && lead_ok(bus.DATA2);

    // Sticky format error, cleared only by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_CAPTURE) && !w_frame_ok) begin
            r_err <= 1'b1;
        end
    end

    assign bus.ERR = r_err;
`else
    // Leading bits are don't-care when checking is compiled out
    logic w_unused_hi;
    assign w_unused_hi = ^{bus.DATA1[FRAME_BITS-1:SAMPLE_W],
                           bus.DATA2[FRAME_BITS-1:SAMPLE_W]};
    assign w_frame_ok  = 1'b1;
    assign bus.ERR     = 1'b0;
`endif

    // Frame state machine; CS and SCLK are updated together with the state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 4'd0;
            r_quiet_cnt <= 8'd0;
            r_cs        <= 1'b1;
            r_sclk      <= 1'b1;
            r_valid     <= 1'b0;
            r_sample1   <= '0;
            r_sample2   <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.EN) begin
                        r_state   <= ST_LEAD;
                        r_cs      <= 1'b0;
                        r_bit_cnt <= 4'd0;
                    end
                end
                ST_LEAD: begin
                    if (w_tick) begin
                        r_state   <= ST_LOW;
                        r_sclk    <= 1'b0;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
                ST_LOW: begin
                    if (w_tick) begin
                        r_state <= ST_HIGH;
                        r_sclk  <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (w_tick) begin
                        // Counter wraps to zero on the 16th LOW entry
                        if (r_bit_cnt == 4'd0) begin
                            r_state <= ST_CAPTURE;
                        end else begin
                            r_state   <= ST_LOW;
                            r_sclk    <= 1'b0;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    r_state     <= ST_QUIET;
                    r_cs        <= 1'b1;
                    r_quiet_cnt <= 8'd0;
                    if (w_frame_ok) begin
                        r_sample1 <= bus.DATA1[SAMPLE_W-1:0];
                        r_sample2 <= bus.DATA2[SAMPLE_W-1:0];
                        r_valid   <= 1'b1;
                    end
                end
                ST_QUIET: begin
                    if (r_quiet_cnt == c_quiet_last) begin
                        if (bus.EN) begin
                            r_state   <= ST_LEAD;
                            r_cs      <= 1'b0;
                            r_bit_cnt <= 4'd0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_quiet_cnt <= r_quiet_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cs    <= 1'b1;
                    r_sclk  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.CS      = r_cs;
    assign bus.SCLK    = r_sclk;
    assign bus.BUSY    = ~r_cs;
    assign bus.VALID   = r_valid;
    assign bus.SAMPLE1 = r_sample1;
    assign bus.SAMPLE2 = r_sample2;

endmodule : ad1_frame_sequencer
`default_nettype wire

// File: tb/tb_ad1_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ad1_frame_sequencer
//  Description : Self-checking bench for ad1_frame_sequencer. A frame-timing
//                model predicts every output from the cycle offset within the
//                frame; directed scenarios pin latency, length, gap, period,
//                sample capture, reset and EN-drop behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ad1_frame_sequencer;

    localparam int D     = 4;
    localparam int Q     = 8;
    localparam int FRAME = 33 * D + 1;

    logic CLK;
    logic RST;

    ad1_frame_sequencer_if bus_if ();

    ad1_frame_sequencer #(
        .CLK_DIV      (D),
        .QUIET_CYCLES (Q)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- frame-timing model ----------------
    int          t;          // cycles since CS fall, -1 when idle
    logic        m_valid;
    logic        m_err;
    logic [11:0] m_s1;
    logic [11:0] m_s2;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            t = -1; m_valid = 0; m_err = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            m_valid = 0;
            if (t == -1 || t == FRAME + Q - 1)
                t = bus_if.EN ? 0 : -1;
            else
                t = t + 1;
            if (t == FRAME) begin
`ifdef AD1_FRAME_CHECK_EN
                if (bus_if.DATA1[15:12] != 0 || bus_if.DATA2[15:12] != 0) begin
                    m_err = 1;
                end else begin
                    m_valid = 1; m_s1 = bus_if.DATA1[11:0]; m_s2 = bus_if.DATA2[11:0];
                end
`else
                m_valid = 1; m_s1 = bus_if.DATA1[11:0]; m_s2 = bus_if.DATA2[11:0];
`endif
            end
        end
    end

    function automatic logic exp_cs(int tt);
        return !(tt >= 0 && tt < FRAME);
    endfunction

    function automatic logic exp_sclk(int tt);
        if (tt < D || tt >= 33 * D) return 1'b1;
        return (((tt - D) / D) % 2) == 1;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic prev_cs   = 1'b1;
    logic prev_sclk = 1'b1;
    int   sclk_falls = 0;
    int   fall_cyc   = 0;
    int   rise_cyc   = 0;
    int   valid_cnt  = 0;

    // One cycle: sample on the falling edge, compare with the model, track edges
    task automatic step();
        logic [28:0] act_v, exp_v;
        @(negedge CLK);
        act_v = {bus_if.CS, bus_if.SCLK, bus_if.BUSY, bus_if.VALID, bus_if.ERR,
                 bus_if.SAMPLE1, bus_if.SAMPLE2};
        exp_v = {exp_cs(t), exp_sclk(t), !exp_cs(t), m_valid, m_err, m_s1, m_s2};
        check("model{cs,sclk,busy,valid,err,s1,s2}", 32'(act_v), 32'(exp_v));
        if (prev_cs && !bus_if.CS) begin
            sclk_falls = 0;
            fall_cyc   = cyc;
        end
        if (!bus_if.CS && prev_sclk && !bus_if.SCLK) sclk_falls++;
        if (!prev_cs && bus_if.CS) rise_cyc = cyc;
        if (bus_if.VALID) valid_cnt++;
        prev_cs   = bus_if.CS;
        prev_sclk = bus_if.SCLK;
    endtask

    task automatic wait_cs(input logic val, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus_if.CS === val) return;
        end
        check("timeout_wait_cs", 32'(bus_if.CS), 32'(val));
    endtask

    task automatic wait_falls(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (sclk_falls >= n) return;
        end
        check("timeout_wait_falls", 32'(sclk_falls), 32'(n));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs"},    32'(bus_if.CS),      32'd1);
        check({tag, "_sclk"},  32'(bus_if.SCLK),    32'd1);
        check({tag, "_busy"},  32'(bus_if.BUSY),    32'd0);
        check({tag, "_valid"}, 32'(bus_if.VALID),   32'd0);
        check({tag, "_s1"},    32'(bus_if.SAMPLE1), 32'd0);
        check({tag, "_s2"},    32'(bus_if.SAMPLE2), 32'd0);
        check({tag, "_err"},   32'(bus_if.ERR),     32'd0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int c0, f1, r1, saved_fall;
        RST = 1'b1;
        bus_if.EN = 1'b0;
        bus_if.DATA1 = 16'h0000;
        bus_if.DATA2 = 16'h0000;
        repeat (3) step();
        check_reset_outputs("reset");
        RST = 1'b0;
        repeat (5) step();
        check("idle_no_cs_fall", 32'(bus_if.CS), 32'd1);

        // Single frame: latency, length, 16 SCLK falls, captured samples
        bus_if.DATA1 = 16'h0ABC;
        bus_if.DATA2 = 16'h0123;
        bus_if.EN = 1'b1;
        c0 = cyc;
        wait_cs(1'b0, 10);
        check("cs_fall_latency", 32'(fall_cyc - c0), 32'd1);
        bus_if.EN = 1'b0;
        wait_cs(1'b1, 200);
        check("frame_len", 32'(rise_cyc - fall_cyc), 32'd133);
        check("sclk_falls", 32'(sclk_falls), 32'd16);
        check("valid_at_rise", 32'(bus_if.VALID), 32'd1);
        check("sample1", 32'(bus_if.SAMPLE1), 32'h0ABC);
        check("sample2", 32'(bus_if.SAMPLE2), 32'h0123);
        c0 = valid_cnt;
        repeat (30) step();
        check("single_valid", 32'(valid_cnt), 32'(c0));
        check("idle_after_frame", 32'(bus_if.CS), 32'd1);
        check("sample1_held", 32'(bus_if.SAMPLE1), 32'h0ABC);

        // Continuous conversion: quiet gap and period
        bus_if.DATA1 = 16'h0FED;
        bus_if.DATA2 = 16'h0777;
        bus_if.EN = 1'b1;
        wait_cs(1'b0, 10);
        f1 = fall_cyc;
        wait_cs(1'b1, 200);
        r1 = rise_cyc;
        check("sample1_b", 32'(bus_if.SAMPLE1), 32'h0FED);
        check("sample2_b", 32'(bus_if.SAMPLE2), 32'h0777);
        wait_cs(1'b0, 50);
        check("quiet_gap", 32'(fall_cyc - r1), 32'd8);
        check("period", 32'(fall_cyc - f1), 32'd141);

        // EN dropped during bit 5: frame completes, then idle
        wait_falls(5, 200);
        bus_if.EN = 1'b0;
        wait_cs(1'b1, 200);
        check("endrop_valid", 32'(bus_if.VALID), 32'd1);
        check("endrop_falls", 32'(sclk_falls), 32'd16);
        saved_fall = fall_cyc;
        repeat (60) step();
        check("endrop_no_refire", 32'(fall_cyc), 32'(saved_fall));
        check("endrop_idle_cs", 32'(bus_if.CS), 32'd1);

        // Reset in the 7th SCLK-low phase
        bus_if.EN = 1'b1;
        wait_cs(1'b0, 10);
        wait_falls(7, 200);
        check("pre_reset_sclk_low", 32'(bus_if.SCLK), 32'd0);
        #1 RST = 1'b1;
        #1 check_reset_outputs("midreset");
        step();
        RST = 1'b0;
        wait_cs(1'b0, 10);
        wait_cs(1'b1, 200);
        check("post_reset_falls", 32'(sclk_falls), 32'd16);
        check("post_reset_len", 32'(rise_cyc - fall_cyc), 32'd133);
        check("post_reset_valid", 32'(bus_if.VALID), 32'd1);
        bus_if.EN = 1'b0;
        repeat (20) step();

        // Nonzero leading bits on channel 1
        bus_if.DATA1 = 16'h1ABC;
        bus_if.DATA2 = 16'h0123;
        bus_if.EN = 1'b1;
        wait_cs(1'b0, 10);
        bus_if.EN = 1'b0;
        wait_cs(1'b1, 200);
`ifdef AD1_FRAME_CHECK_EN
        check("bad_no_valid", 32'(bus_if.VALID), 32'd0);
        check("bad_s1_held", 32'(bus_if.SAMPLE1), 32'h0FED);
        check("bad_err_set", 32'(bus_if.ERR), 32'd1);
`else
        check("hi_ignored_valid", 32'(bus_if.VALID), 32'd1);
        check("hi_ignored_s1", 32'(bus_if.SAMPLE1), 32'h0ABC);
        check("hi_ignored_err", 32'(bus_if.ERR), 32'd0);
`endif
        repeat (20) step();
        bus_if.DATA1 = 16'h0456;
        bus_if.EN = 1'b1;
        wait_cs(1'b0, 10);
        bus_if.EN = 1'b0;
        wait_cs(1'b1, 200);
        check("good_after_valid", 32'(bus_if.VALID), 32'd1);
        check("good_after_s1", 32'(bus_if.SAMPLE1), 32'h0456);
`ifdef AD1_FRAME_CHECK_EN
        check("err_sticky", 32'(bus_if.ERR), 32'd1);
`else
        check("err_tied_low", 32'(bus_if.ERR), 32'd0);
`endif
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ad1_frame_sequencer
`default_nettype wire
